muldiv_unit: RTL and testbench

Iterative multiply/divide execution unit for the RV32M extension. It sits in EX beside the main ALU and takes its operands from the same forwarding muxes. The unit raises `busy` so the hazard unit can stall IF/ID/EX, and returns one `XLEN`-bit result with a single-cycle `done` pulse. Operation is selected by `funct3` of an OP-opcode instruction with funct7 = 0000001.

---
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency XLEN+2 cycles from accept to done; divide-by-zero/overflow take 1 cycle when EARLY_OUT=1.
// No backpressure: start is taken only while not busy; flush aborts and drops the operation.
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_q;
    logic                neg_r;
    logic                dz_q;
    logic [CW-1:0]       cnt_q;

    logic                accept;
    logic                signed_a;
    logic                signed_b;
    logic                sa;
    logic                sb;
    logic [XLEN-1:0]     abs_a;
    logic [XLEN-1:0]     abs_b;
    logic                b_zero;
    logic                ovf;
    logic                early;
    logic [XLEN-1:0]     early_res;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   div_next;

    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo_f;
    logic [XLEN-1:0]     rem_f;
    logic [XLEN-1:0]     fix_res;

    // Issue decode: operand signedness, magnitudes and the RISC-V special divide cases
    always_comb begin
        accept    = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
        signed_a  = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
        signed_b  = signed_a && (funct3 != 3'b010);
        sa        = signed_a && op_a[XLEN-1];
        sb        = signed_b && op_b[XLEN-1];
        abs_a     = sa ? -op_a : op_a;
        abs_b     = sb ? -op_b : op_b;
        b_zero    = (op_b == '0);
        ovf       = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        early     = EARLY_OUT && funct3[2] && (b_zero || ovf);
        early_res = '0;
        if (b_zero) begin
            early_res = funct3[1] ? op_a : '1;
        end else begin
            early_res = funct3[1] ? '0 : op_a;
        end
    end

    // One iteration step: multiply adds then shifts right, divide shifts left then trial-subtracts
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Sign fix-up and result selection; divide-by-zero forces an all-ones quotient
    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        quo_f   = dz_q ? '1 : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
        rem_f   = neg_r ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_res = '0;
        case (op_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_f;
            default:                fix_res = rem_f;
        endcase
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = accept ? (early ? S_DONE : S_CALC) : S_IDLE;
            S_CALC:         if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
            S_FIX:          state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture on accept, then one iteration per CALC cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            op_q    <= funct3;
            mcand_q <= abs_b;
            acc_q   <= {{XLEN{1'b0}}, abs_a};
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            dz_q    <= b_zero;
            cnt_q   <= '0;
        end else if (state_q == S_CALC) begin
            acc_q   <= op_q[2] ? div_next : mul_next;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Result register, written only on entry to DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
        end else if (accept && early) begin
            result <= early_res;
        end else if (state_q == S_FIX && !flush) begin
            result <= fix_res;
        end
    end

    assign busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: two instances (EARLY_OUT on/off) driven in parallel.
// Directed vector table, randomized ops against an arithmetic reference model,
// plus flush, back-to-back and asynchronous-reset sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;

    logic        busy_e, done_e, busy_n, done_n;
    logic [31:0] result_e, result_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u_eo (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .busy(busy_e), .done(done_e), .result(result_e)
    );

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) u_ne (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .busy(busy_n), .done(done_n), .result(result_n)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // RISC-V special divide cases that complete early when EARLY_OUT is set
    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Reference: plain 64-bit arithmetic plus the RISC-V divide-by-zero rule
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op to both units; k = edges after the accept edge until done is seen
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int k_n, output int k_e, output int b_n, output int b_e,
                          output logic [31:0] r_n, output logic [31:0] r_e);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        k_n = -1; k_e = -1; b_n = 0; b_e = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (busy_n) b_n++;
            if (busy_e) b_e++;
            if (done_n && k_n < 0) k_n = k;
            if (done_e && k_e < 0) k_e = k;
            if (k_n >= 0 && k_e >= 0) break;
        end
        r_n = result_n;
        r_e = result_e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          k_n, k_e, b_n, b_e, k;
        logic [31:0] r_n, r_e, prev_n, prev_e, a, b, exp;
        logic [2:0]  f;
        bit          sp;
        int          seen_n, seen_e;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tbl[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        tbl[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        tbl[12] = '{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF};
        tbl[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
        tbl[14] = '{3'd3, 32'h8000_0000,  32'd2,         32'd1};
        tbl[15] = '{3'd4, 32'h8000_0000,  32'd1,         32'h8000_0000};
        tbl[16] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        tbl[17] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};

        // Reset state
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy_n", {31'd0, busy_n}, 32'd0);
        chk("reset done_n", {31'd0, done_n}, 32'd0);
        chk("reset result_n", result_n, 32'd0);
        chk("reset busy_e", {31'd0, busy_e}, 32'd0);
        chk("reset result_e", result_e, 32'd0);
        rst = 1'b1;

        // Directed vectors: values, latency and busy duration for both variants
        for (int i = 0; i < 18; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, k_n, k_e, b_n, b_e, r_n, r_e);
            sp = is_special(tbl[i].f, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d result_n", i), r_n, tbl[i].exp);
            chk($sformatf("vec%0d result_e", i), r_e, tbl[i].exp);
            chk($sformatf("vec%0d latency_n", i), 32'(k_n + 1), 32'd34);
            chk($sformatf("vec%0d latency_e", i), 32'(k_e + 1), sp ? 32'd1 : 32'd34);
            chk($sformatf("vec%0d busy_cycles_n", i), 32'(b_n), 32'd33);
            chk($sformatf("vec%0d busy_cycles_e", i), 32'(b_e), sp ? 32'd0 : 32'd33);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            exp = ref_model(f, a, b);
            run_op(f, a, b, k_n, k_e, b_n, b_e, r_n, r_e);
            chk($sformatf("rand%0d f=%0d a=%h b=%h result_n", i, f, a, b), r_n, exp);
            chk($sformatf("rand%0d f=%0d a=%h b=%h result_e", i, f, a, b), r_e, exp);
        end

        // Flush at edge T+10 of a DIV: no done, result held
        prev_n = result_n;
        prev_e = result_e;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy_n", {31'd0, busy_n}, 32'd0);
        chk("flush busy_e", {31'd0, busy_e}, 32'd0);
        seen_n = 0; seen_e = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_n) seen_n++;
            if (done_e) seen_e++;
            @(negedge clk);
        end
        chk("flush done_n count", 32'(seen_n), 32'd0);
        chk("flush done_e count", 32'(seen_e), 32'd0);
        chk("flush result_n held", result_n, prev_n);
        chk("flush result_e held", result_e, prev_e);

        // start together with flush in IDLE is not accepted
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("start+flush done_e", {31'd0, done_e}, 32'd0);
        chk("start+flush result_e", result_e, prev_e);
        @(negedge clk);
        chk("start+flush busy_n", {31'd0, busy_n}, 32'd0);

        // Back-to-back: second MUL issued in the DONE cycle of the first
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd12345; op_b = 32'd678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done_n && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b first latency", 32'(k + 1), 32'd34);
        chk("b2b first result", result_n, 32'd8369910);
        start = 1'b1; funct3 = 3'd0; op_a = 32'h0000_FFFF; op_b = 32'h0001_0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done_n && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b second latency", 32'(k + 1), 32'd34);
        chk("b2b second result_n", result_n, 32'hFFFF_FFFF);
        chk("b2b second result_e", result_e, 32'hFFFF_FFFF);

        // Asynchronous reset mid-CALC, observed before any further clock edge
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset busy_n", {31'd0, busy_n}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async rst busy_n", {31'd0, busy_n}, 32'd0);
        chk("async rst busy_e", {31'd0, busy_e}, 32'd0);
        chk("async rst done_n", {31'd0, done_n}, 32'd0);
        chk("async rst result_n", result_n, 32'd0);
        chk("async rst result_e", result_e, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Unit works again after reset
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, k_n, k_e, b_n, b_e, r_n, r_e);
        chk("post-reset result_n", r_n, 32'hFFFF_FFFD);
        chk("post-reset latency_n", 32'(k_n + 1), 32'd34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
